// File: rtl/kgs_mp_sequencer.sv
// Multi-precision add/subtract sequencer around a single KGS prefix adder.
// Operands are WORDS*W bits wide and are streamed through the adder one
// W-bit word per cycle, least significant word first. The carry between
// words is registered.
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// sequencer is in IDLE or DONE. start is ignored while busy=1. done is a
// one-cycle pulse, and it marks the point where sum and cout are valid.
// sum and cout hold their values until a later operation overwrites them.

// KGS: Kogge-Stone parallel-prefix adder for (size-1)-bit operands.
// Prefix position 0 carries cin, so the tree spans `size` positions and
// needs LL >= clog2(size) levels.
module KGS #(
  parameter int size = 32,
  parameter int LL   = 5
) (
  input  logic [size-2:0] A,
  input  logic [size-2:0] B,
  input  logic            cin,
  output logic [size-2:0] sum,
  output logic            cout
);

  logic [size-1:0] hg;
  logic [size-1:0] hp;
  logic [size-1:0] g;
  logic [size-1:0] p;

  // Prefix tree: after the last level g[i] is the carry out of positions 0..i.
  always_comb begin
    hg = {A & B, cin};
    hp = {A ^ B, 1'b0};
    g  = hg;
    p  = hp;
    for (int lvl = 0; lvl < LL; lvl++) begin
      // Walk downward so that g/p at i-d still hold the previous level's values.
      for (int i = size - 1; i >= 0; i--) begin
        if (i >= (1 << lvl)) begin
          g[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
          p[i] = p[i] & p[i - (1 << lvl)];
        end else begin
          // This group already reaches position 0, so it cannot propagate further.
          p[i] = 1'b0;
        end
      end
    end
    sum  = hp[size-1:1] ^ g[size-2:0];
    cout = g[size-1];
  end

endmodule

module kgs_mp_sequencer #(
  parameter int size  = 32,
  parameter int LL    = 5,
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic [WORDS*(size-1)-1:0] A,
  input  logic [WORDS*(size-1)-1:0] B,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [WORDS*(size-1)-1:0] sum,
  output logic                      cout,
  output logic [1:0]                dbg_state
);

  localparam int W  = size - 1;
  localparam int N  = WORDS * W;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          accept;
  logic          last;

  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic          sub_reg;
  logic          carry;
  logic [IW-1:0] idx;

  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic [W-1:0]  add_sum;
  logic          add_cout;

  // Word select for the adder. For subtract, B is inverted; the +1 comes from the seeded carry.
  always_comb begin
    add_a = a_reg[int'(idx) * W +: W];
    add_b = b_reg[int'(idx) * W +: W] ^ {W{sub_reg}};
  end

  KGS #(
    .size (size),
    .LL   (LL)
  ) u_kgs (
    .A    (add_a),
    .B    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic. A start in DONE is accepted exactly as it is in IDLE.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (idx == IW'(WORDS - 1)) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, plus one word of result per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_reg   <= A;
      b_reg   <= B;
      sub_reg <= sub;
      carry   <= sub ? 1'b1 : cin;
      idx     <= '0;
    end else if (state == RUN) begin
      sum[int'(idx) * W +: W] <= add_sum;
      carry                   <= add_cout;
      idx                     <= idx + IW'(1);
      if (last) begin
        cout <= add_cout;
      end
    end
  end

  // Status outputs are decoded directly from the state register.
  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_kgs_mp_sequencer.sv
// Directed testbench for kgs_mp_sequencer at default parameters (N = 124).
module tb_kgs_mp_sequencer;

  localparam int N     = 124;
  localparam int WORDS = 4;
  localparam int LAT   = WORDS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string        name;
    logic         sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[9];

  kgs_mp_sequencer #(.size(32), .LL(5), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one request. The bench drives and samples on the falling edge.
  task automatic issue(input logic s, input logic c, input logic [N-1:0] a, input logic [N-1:0] b);
    sub   = s;
    cin   = c;
    A     = a;
    B     = b;
    start = 1'b1;
  endtask

  // Count falling edges until done is seen, giving up after 20. start is dropped after the first edge.
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
    end while (!done && cycles < 20);
  endtask

  // Watch n cycles and count any done pulses seen.
  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [N-1:0] ones;
    logic [N-1:0] w0_w1_ones;
    ones       = '1;
    w0_w1_ones = 124'h3FFF_FFFF_FFFF_FFFF;

    vecs[0] = '{"add_basic",    1'b0, 1'b0, 124'h1E0,      124'h00F, 124'h1EF,      1'b0};
    vecs[1] = '{"add_cin",      1'b0, 1'b1, 124'h1E0,      124'h00F, 124'h1F0,      1'b0};
    vecs[2] = '{"word_carry",   1'b0, 1'b0, 124'h7FFFFFFF, 124'h1,   124'h80000000, 1'b0};
    vecs[3] = '{"ovf_cin",      1'b0, 1'b1, ones,          124'h0,   124'h0,        1'b1};
    vecs[4] = '{"ovf_ones",     1'b0, 1'b1, ones,          ones,     ones,          1'b1};
    vecs[5] = '{"sub_pos",      1'b1, 1'b0, 124'h7,        124'h5,   124'h2,        1'b1};
    vecs[6] = '{"sub_neg",      1'b1, 1'b1, 124'h5,        124'h7,   {{123{1'b1}}, 1'b0}, 1'b0};
    vecs[7] = '{"chain_2words", 1'b0, 1'b0, w0_w1_ones,    124'h1,   124'h4000_0000_0000_0000, 1'b0};
    vecs[8] = '{"sub_equal",    1'b1, 1'b0, 124'h123,      124'h123, 124'h0,        1'b1};

    // Reset with start held high: nothing may begin.
    rst = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b1; A = 124'h55; B = 124'h66;
    repeat (2) @(negedge clk);
    check("rst_busy", N'(busy), N'(1'b0));
    check("rst_done", N'(done), N'(1'b0));
    check("rst_sum",  sum,      '0);
    check("rst_cout", N'(cout), N'(1'b0));
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", N'(busy), N'(1'b0));

    // Table of single operations.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b);
      wait_done(cyc);
      check({vecs[i].name, "_lat"},  N'(cyc),  N'(LAT));
      check({vecs[i].name, "_sum"},  sum,      vecs[i].exp_sum);
      check({vecs[i].name, "_cout"}, N'(cout), N'(vecs[i].exp_cout));
      @(negedge clk);
      check({vecs[i].name, "_idle"}, N'(busy | done), N'(1'b0));
      check({vecs[i].name, "_hold"}, sum, vecs[i].exp_sum);
    end

    // start while busy is ignored, and operand changes after capture have no effect.
    issue(1'b0, 1'b0, 124'h10, 124'h20);
    @(negedge clk);
    check("busy_run", N'(busy), N'(1'b1));
    issue(1'b1, 1'b1, 124'hFFFF, 124'h1);
    @(negedge clk);
    start = 1'b0; A = 124'h999; B = 124'h777;
    cyc = 2;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ignore_lat",  N'(cyc),  N'(LAT));
    check("ignore_sum",  sum,      124'h30);
    check("ignore_cout", N'(cout), N'(1'b0));
    count_done(8, pulses);
    check("ignore_no_second_done", N'(pulses), N'(0));

    // Back-to-back: a start in the DONE cycle is accepted.
    issue(1'b0, 1'b0, 124'h100, 124'h23);
    wait_done(cyc);
    check("b2b_first_sum", sum, 124'h123);
    issue(1'b1, 1'b0, 124'h1000, 124'h1);
    wait_done(cyc);
    check("b2b_second_lat",  N'(cyc),  N'(LAT));
    check("b2b_second_sum",  sum,      124'hFFF);
    check("b2b_second_cout", N'(cout), N'(1'b1));

    // Reset during RUN cycle 2 aborts the operation with no done pulse.
    issue(1'b0, 1'b1, ones, 124'h0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", N'(busy), N'(1'b0));
    check("abort_sum",  sum,      '0);
    check("abort_cout", N'(cout), N'(1'b0));
    count_done(8, pulses);
    check("abort_no_done", N'(pulses), N'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kgs_mp_sequencer.md
Name: kgs_mp_sequencer

Overview:
- Multi-precision add/subtract controller built around one shared KGS tree adder instance, `KGS #(size, LL)`, with a word width of W = size-1 bits.
- Adds two WORDS*W-bit operands by streaming one W-bit word per cycle through the adder, least significant word first, and registering the carry between words.
- Sits between a host that issues start/operands and the combinational KGS datapath. Lets wide additions reuse a single 31-bit adder instead of a wider tree.

Parameters:
- size, 32, KGS adder size; word width W = size-1.
- LL, 5, KGS tree level count, passed straight to the adder instance.
- WORDS, 4, number of W-bit words per operand; total operand width N = WORDS*W (124 at defaults).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when busy=0.
- sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1 with cin ignored.
- A  input  N  operand A, captured on the accepted start.
- B  input  N  operand B, captured on the accepted start.
- cin  input  1  carry-in for addition, captured on the accepted start.
- busy  output  1  high while the sequencer is in RUN.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  N  result, registered and held until the next accepted start.
- cout  output  1  final carry-out; for subtract, 1 = no borrow (A>=B).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; word index and carry register cleared. A reset mid-RUN aborts the operation with no done pulse.
- States:
  - IDLE: start=1 → capture A, B, sub, cin; carry <= (sub ? 1 : cin); idx <= 0; go to RUN.
  - RUN: busy=1.
  - DONE: lasts exactly one cycle with done=1, then goes to IDLE. A start sampled in DONE is accepted exactly as in IDLE (back-to-back operation).
- Datapath, each RUN cycle:
  - adder.A = A_reg word idx.
  - adder.B = B_reg word idx, XORed with {W{sub_reg}}.
  - adder.cin = carry.
  - At the clock edge: sum word idx <= adder.sum; carry <= adder.cout; idx <= idx+1.
  - When idx = WORDS-1: cout <= adder.cout; go to DONE.
- Latency:
  - Start accepted at edge k → RUN occupies edges k+1 .. k+WORDS.
  - done=1 in the cycle after edge k+WORDS, i.e. WORDS+1 cycles after start was sampled.
  - Throughput is one operation per WORDS+1 cycles.
- Operand isolation:
  - start while busy=1 is ignored.
  - A, B, cin and sub changes after capture do not affect the operation in progress.
- Output update:
  - sum words update progressively during RUN, so sum is valid only when done=1 or afterwards.
  - sum and cout are not cleared at the start of a new operation.
- Arithmetic: modulo 2^N. The carry between words is exactly the KGS cout, with no extra logic.
- WORDS=1 is legal: a single RUN cycle, then DONE.
- idx width is clog2(WORDS), minimum 1 bit.

Test Plan:
- Reset: hold rst for 2 cycles, with start=1 during reset → busy=0, done=0, sum=0, cout=0; no operation begins.
- Basic add: A=0x1E0, B=0x00F, cin=0, start pulse → done exactly 5 cycles later, sum=0x1EF, cout=0. Repeat with cin=1 → sum=0x1F0.
- Inter-word carry: A=0x7FFFFFFF (word0 all ones), B=1, cin=0 → sum=0x80000000 (word1 bit0 set, word0=0), cout=0.
- Full overflow: A=all ones (124 bits), B=0, cin=1 → sum=0, cout=1. Separately, A=all ones, B=all ones, cin=1 → sum=all ones, cout=1.
- Subtract: sub=1, A=7, B=5 → sum=2, cout=1. sub=1, A=5, B=7, cin=1 → sum=2^124-2, cout=0 (cin ignored).
- Control: start again during RUN with different operands → ignored, first result unchanged. start in the DONE cycle → new operation runs back to back. rst asserted at RUN cycle 2 → IDLE, no done pulse, sum=0.
